// File: rtl/lsu_pkg.sv
// lsu_pkg: op encodings, FSM state enum and request-classification helpers
// shared by the load/store unit.
package lsu_pkg;

    localparam logic [2:0] OP_LW  = 3'd0;
    localparam logic [2:0] OP_LH  = 3'd1;
    localparam logic [2:0] OP_LHU = 3'd2;
    localparam logic [2:0] OP_LB  = 3'd3;
    localparam logic [2:0] OP_LBU = 3'd4;
    localparam logic [2:0] OP_SW  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SB  = 3'd7;

    typedef enum logic [2:0] {S_IDLE, S_RD, S_RMW_RD, S_WR, S_RESP} state_t;

    function automatic logic is_load(input logic [2:0] op);
        return op <= OP_LBU;
    endfunction

    function automatic logic is_subword_store(input logic [2:0] op);
        return (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        return ((op == OP_LW || op == OP_SW) && off != 2'b00) ||
               ((op == OP_LH || op == OP_LHU || op == OP_SH) && off[0]);
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: big-endian lane extract/extend for loads and lane merge for
// sub-word stores, keyed by op and byte offset.
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  i_op,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_rword,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_load,
    output logic [31:0] o_merged
);

    // Byte k sits at bit 8*(3-k); for a 2-bit k, 3-k is simply ~k.
    logic [4:0]  w_bsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_bmask;

    assign w_bsh   = {~i_off, 3'b000};
    assign w_byte  = 8'(i_rword >> w_bsh);
    assign w_half  = i_off[1] ? i_rword[15:0] : i_rword[31:16];
    assign w_bmask = 32'h0000_00FF << w_bsh;

    always_comb begin
        o_load   = (i_op == OP_LB)  ? {{24{w_byte[7]}}, w_byte} :
                   (i_op == OP_LBU) ? {24'b0, w_byte} :
                   (i_op == OP_LH)  ? {{16{w_half[15]}}, w_half} :
                   (i_op == OP_LHU) ? {16'b0, w_half} : i_rword;
        o_merged = (i_op == OP_SB) ? ((i_rword & ~w_bmask) | ({24'b0, i_wdata[7:0]} << w_bsh)) :
                   (i_op == OP_SH) ? (i_off[1] ? {i_rword[31:16], i_wdata[15:0]}
                                               : {i_wdata[15:0], i_rword[15:0]}) : i_wdata;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: single-outstanding load/store initiator with read-modify-write
// for SH/SB. Optional misalignment trap under LSU_ALIGN_CHECK_EN.
module lsu_mem_master
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_op,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_t            r_state, w_next;
    logic [2:0]        r_op;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_accept;
    logic              w_misal;
    logic [31:0]       w_load;
    logic [31:0]       w_merged;

    assign w_accept = (r_state == S_IDLE) && req_valid;

`ifdef LSU_ALIGN_CHECK_EN
    logic r_err;
    assign w_misal  = is_misaligned(req_op, req_addr[1:0]);
    assign resp_err = (r_state == S_RESP) && r_err;
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (w_accept)
            r_err <= w_misal;
    end
`else
    assign w_misal  = 1'b0;
    assign resp_err = 1'b0;
`endif

    lsu_lane_align u_align (
        .i_op    (r_op),
        .i_off   (r_addr[1:0]),
        .i_rword (mem_rdata),
        .i_wdata (r_wdata),
        .o_load  (w_load),
        .o_merged(w_merged)
    );

    always_ff @(posedge clk) begin
        if (rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid)
                          w_next = w_misal                  ? S_RESP   :
                                   is_load(req_op)          ? S_RD     :
                                   is_subword_store(req_op) ? S_RMW_RD : S_WR;
            S_RD:     w_next = S_RESP;
            S_RMW_RD: w_next = S_WR;
            S_WR:     w_next = S_RESP;
            default:  w_next = S_IDLE;
        endcase
    end

    // r_wdata holds the raw store data until RMW_RD replaces it with the merged word.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_op    <= OP_LW;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else if (w_accept) begin
            r_op    <= req_op;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_rdata <= '0;
        end else if (r_state == S_RD) begin
            r_rdata <= w_load;
        end else if (r_state == S_RMW_RD) begin
            r_wdata <= w_merged;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign mem_read   = (r_state == S_RD) || (r_state == S_RMW_RD);
    assign mem_write  = (r_state == S_WR);
    assign mem_addr   = {r_addr[ADDR_W-1:2], 2'b00};
    assign mem_wdata  = r_wdata;

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: directed and random load/store traffic checked against a
// byte-array reference memory model; build with LSU_ALIGN_CHECK_EN to test the trap.
module tb_lsu_mem_master;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = 3'd0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    lsu_mem_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Memory seen by the DUT (only the low 6 address bits matter).
    logic [7:0] mem [64];
    logic [7:0] ref_mem [64];

    assign mem_rdata = {mem[{mem_addr[5:2], 2'd0}], mem[{mem_addr[5:2], 2'd1}],
                        mem[{mem_addr[5:2], 2'd2}], mem[{mem_addr[5:2], 2'd3}]};

    always @(posedge clk) begin
        if (mem_write) begin
            mem[{mem_addr[5:2], 2'd0}] <= mem_wdata[31:24];
            mem[{mem_addr[5:2], 2'd1}] <= mem_wdata[23:16];
            mem[{mem_addr[5:2], 2'd2}] <= mem_wdata[15:8];
            mem[{mem_addr[5:2], 2'd3}] <= mem_wdata[7:0];
        end
    end

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          exp_cycle = -1;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] exp_rdata = '0;
    logic        exp_err = 1'b0;
    logic [31:0] got_rdata = '0;
    logic [31:0] cur_addr = '0;

    task automatic check(input string n, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", n, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle compare against the expected response schedule.
    always @(negedge clk) begin
        if (!rst) begin
            check("resp_valid", 32'(resp_valid), 32'(cyc == exp_cycle));
            if (cyc == exp_cycle) begin
                check("resp_rdata", resp_rdata, exp_rdata);
                check("resp_err", 32'(resp_err), 32'(exp_err));
                got_rdata <= resp_rdata;
            end
            check("rd_wr_excl", 32'(mem_read & mem_write), 32'd0);
            if (mem_read || mem_write)
                check("mem_addr", mem_addr, {cur_addr[31:2], 2'b00});
            rd_cnt <= rd_cnt + int'(mem_read);
            wr_cnt <= wr_cnt + int'(mem_write);
        end
    end

    function automatic logic [31:0] word_of(input int w, input logic is_ref);
        int a = w & 60;
        return is_ref ? {ref_mem[a], ref_mem[a+1], ref_mem[a+2], ref_mem[a+3]}
                      : {mem[a], mem[a+1], mem[a+2], mem[a+3]};
    endfunction

    // Reference: byte-level semantics on ref_mem.
    task automatic model(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output logic [31:0] rd, output logic err, output int lat,
                         output int rdn, output int wrn);
        int b = int'(addr[5:0]);
        int w = b & 60;
        int h = w + (addr[1] ? 2 : 0);
        logic [15:0] hv = {ref_mem[h], ref_mem[h+1]};
        logic [7:0]  bv = ref_mem[b];
        logic        mis = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
        mis = ((op == OP_LW || op == OP_SW) && addr[1:0] != 2'b00) ||
              ((op == OP_LH || op == OP_LHU || op == OP_SH) && addr[0]);
`endif
        rd = 32'd0; err = mis; lat = 2; rdn = 0; wrn = 0;
        if (mis) lat = 1;
        else case (op)
            OP_LW:  begin rd = word_of(w, 1'b1); rdn = 1; end
            OP_LH:  begin rd = {{16{hv[15]}}, hv}; rdn = 1; end
            OP_LHU: begin rd = {16'd0, hv}; rdn = 1; end
            OP_LB:  begin rd = {{24{bv[7]}}, bv}; rdn = 1; end
            OP_LBU: begin rd = {24'd0, bv}; rdn = 1; end
            OP_SW:  begin
                ref_mem[w] = wd[31:24]; ref_mem[w+1] = wd[23:16];
                ref_mem[w+2] = wd[15:8]; ref_mem[w+3] = wd[7:0]; wrn = 1;
            end
            OP_SH:  begin ref_mem[h] = wd[15:8]; ref_mem[h+1] = wd[7:0]; lat = 3; rdn = 1; wrn = 1; end
            default: begin ref_mem[b] = wd[7:0]; lat = 3; rdn = 1; wrn = 1; end
        endcase
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after RESP.
    task automatic run(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic lit_en, input logic [31:0] lit);
        logic [31:0] rd;
        logic        err;
        int          lat, rdn, wrn, rd0, wr0;
        check("req_ready", 32'(req_ready), 32'd1);
        model(op, addr, wd, rd, err, lat, rdn, wrn);
        exp_rdata = rd; exp_err = err; cur_addr = addr;
        exp_cycle = cyc + lat;
        rd0 = rd_cnt; wr0 = wr_cnt;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        @(posedge clk);
        #1;
        req_valid = 1'($urandom); req_op = 3'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
        repeat (lat + 1) @(negedge clk);
        req_valid = 1'b0;
        check("mem_read_cycles", 32'(rd_cnt - rd0), 32'(rdn));
        check("mem_write_cycles", 32'(wr_cnt - wr0), 32'(wrn));
        check("mem_word", word_of(int'(addr[5:0]), 1'b0), word_of(int'(addr[5:0]), 1'b1));
        if (lit_en) check("resp_literal", got_rdata, lit);
    endtask

    initial begin
        logic [31:0] rd;
        logic        err;
        int          lat, rdn, wrn;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_resp_err", 32'(resp_err), 32'd0);
        check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_wdata", mem_wdata, 32'd0);
        rst = 1'b0;

        run(OP_SW, 32'd8, 32'h11223344, 1'b0, 32'd0);
        check("lit_word8_sw", word_of(8, 1'b0), 32'h11223344);
        run(OP_LW, 32'd8, 32'hFFFF_FFFF, 1'b1, 32'h11223344);
        run(OP_LB, 32'd9, 32'd0, 1'b1, 32'h00000022);
        run(OP_LH, 32'd10, 32'd0, 1'b1, 32'h00003344);
        run(OP_LHU, 32'd8, 32'd0, 1'b1, 32'h00001122);
        run(OP_SB, 32'd11, 32'h00000080, 1'b0, 32'd0);
        check("lit_word8_sb", word_of(8, 1'b0), 32'h11223380);
        run(OP_LB, 32'd11, 32'd0, 1'b1, 32'hFFFFFF80);
        run(OP_LBU, 32'd11, 32'd0, 1'b1, 32'h00000080);
        run(OP_SH, 32'd8, 32'h0000BEEF, 1'b0, 32'd0);
        check("lit_word8_sh", word_of(8, 1'b0), 32'hBEEF3380);
        run(OP_LH, 32'd8, 32'd0, 1'b1, 32'hFFFFBEEF);
        run(OP_SH, 32'd9, 32'h00001234, 1'b0, 32'd0);
`ifdef LSU_ALIGN_CHECK_EN
        check("lit_word8_mis", word_of(8, 1'b0), 32'hBEEF3380);
`else
        check("lit_word8_mis", word_of(8, 1'b0), 32'h12343380);
`endif

        // Reset during WR of an SB; the store data equals the current byte so
        // memory is the same whether or not the in-flight write lands.
        check("req_ready", 32'(req_ready), 32'd1);
        model(OP_SB, 32'h21, {24'd0, ref_mem[33]}, rd, err, lat, rdn, wrn);
        cur_addr = 32'h21;
        req_valid = 1'b1; req_op = OP_SB; req_addr = 32'h21; req_wdata = {24'd0, ref_mem[33]};
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp_cycle = -1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_req_ready", 32'(req_ready), 32'd1);
        check("rstmid_resp_valid", 32'(resp_valid), 32'd0);
        check("rstmid_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        run(OP_LW, 32'h20, 32'd0, 1'b1, word_of(32, 1'b1));

        for (int i = 0; i < 300; i++) begin
            run(3'($urandom), $urandom, $urandom, 1'b0, 32'd0);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 64; i += 4)
            check("final_mem", word_of(i, 1'b0), word_of(i, 1'b1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the CPU MEM stage and the byte-addressed, big-endian, word-write data memory (mem_read/mem_write/address/wdata/rdata).
- Accepts one load or store request at a time and sequences the memory-side control.
- Performs read-modify-write for sub-word stores, because memory writes always cover 4 bytes.
- Returns sign- or zero-extended load data.

Parameters:
ADDR_W, 32, byte address width on both sides
DATA_W, 32, data width; fixed at 32, other values unsupported

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  unit can accept (high only in IDLE)
req_op  in  3  operation code (lsu_pkg)
req_addr  in  ADDR_W  byte address
req_wdata  in  32  store data, right-aligned for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load result; 0 for stores and errors
resp_err  out  1  misaligned request (only with feature), valid with resp_valid
mem_read  out  1  memory read enable
mem_write  out  1  memory write enable
mem_addr  out  ADDR_W  word-aligned address, req_addr with [1:0] = 0
mem_wdata  out  32  full word to write
mem_rdata  in  32  combinational memory read data, valid while mem_read = 1

Behaviour:
- Reset state:
  - All outputs registered or decoded from state.
  - After the reset edge: state = IDLE; req_ready = 1; resp_valid, resp_err, mem_read, mem_write = 0; resp_rdata, mem_addr, mem_wdata = 0.
- Reset mid-operation: abandons the transaction, no response. A write in flight on the same edge as rst is not guaranteed.
- Acceptance: handshake is req_valid & req_ready in IDLE. op, addr and wdata are latched; inputs are ignored until the next IDLE.
- States: IDLE, RD, RMW_RD, WR, RESP.
  - IDLE -> RD on LW/LH/LHU/LB/LBU.
  - IDLE -> WR on SW.
  - IDLE -> RMW_RD on SH/SB.
  - RD -> RESP: mem_read = 1; mem_rdata captured and extracted at the end of the cycle.
  - RMW_RD -> WR: mem_read = 1; word captured and merged with the store lane.
  - WR -> RESP: mem_write = 1 for exactly one cycle; mem_wdata = merged word (SW uses req_wdata unchanged).
  - RESP -> IDLE: resp_valid = 1 for one cycle. No response backpressure.
- mem_read and mem_write are never high together. Both are 0 in IDLE and RESP.
- Latency from the accept edge to the resp_valid cycle:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SH/SB: 3 cycles.
  - Next accept can occur in the cycle after RESP.
- Lane mapping is big-endian.
  - Byte offset k = addr[1:0] maps to bits [31-8k : 24-8k].
  - Halfword at addr[1] = 0 -> [31:16]; addr[1] = 1 -> [15:0].
- Load extension: LB/LH sign-extend, LBU/LHU zero-extend, LW is the raw word.
- Merge: SB replaces only lane k with req_wdata[7:0]; SH replaces only its half with req_wdata[15:0]; all other bytes come from the RMW read.
- Address arithmetic wraps within ADDR_W. No bounds check; out-of-range addresses are the memory's concern.

Optional Feature:
- LSU_ALIGN_CHECK_EN defined:
  - Misaligned requests (LW/SW with addr[1:0] != 0, or LH/LHU/SH with addr[0] = 1) go IDLE -> RESP directly.
  - No memory access; resp_err = 1, resp_rdata = 0. Latency 1.
- Not defined:
  - resp_err tied to 0.
  - Halfword lane selected by addr[1] only; word ops ignore addr[1:0].

Decomposition:
- lsu_pkg:
  - op encodings: OP_LW = 0, OP_LH = 1, OP_LHU = 2, OP_LB = 3, OP_LBU = 4, OP_SW = 5, OP_SH = 6, OP_SB = 7.
  - state enum.
  - helper functions is_load / is_subword_store.
- One sub-module, lsu_lane_align: combinational extract/extend for loads and merge for stores, keyed by op and addr[1:0]. The FSM remains in lsu_mem_master.

Test Plan:
- SW 0x11223344 @8, then LW @8 -> resp_rdata 0x11223344. Memory bytes 8..11 = 11, 22, 33, 44. resp_valid 2 cycles after each accept.
- After the above: LB @9 -> 0x00000022; LH @10 -> 0x00003344; LHU @8 -> 0x00001122.
- SB 0x80 @11 -> word @8 becomes 0x11223380; mem_read seen 1 cycle, then mem_write 1 cycle. Then LB @11 -> 0xFFFFFF80, LBU @11 -> 0x00000080.
- SH 0xBEEF @8 -> word becomes 0xBEEF3380; LH @8 -> 0xFFFFBEEF.
- With LSU_ALIGN_CHECK_EN: SH @9 -> resp_err = 1 one cycle after accept, mem_write never asserted, word @8 unchanged. Without the macro: same stimulus writes lane [31:16].
- Assert rst during WR of an SB: no resp_valid, req_ready = 1 after the edge, mem_read/mem_write = 0. A following LW completes normally.
